cpu_multicycle: RTL and testbench
=================================

// Module: cpu_multicycle
// PURPOSE
//   Parametrised multi-cycle accumulator CPU; successor of the 4-bit fixed X/Y/Z datapath.
//   Fetches INSTR_W-bit words from an external synchronous program ROM, decodes opcode +
//   immediate and updates X (operand), Y (accumulator), Z (snapshot) via an ALU.
//   Adds reset, run/halt control, flags, conditional jump and retire/illegal strobes.
// PARAMETERS
//   DATA_W  4  width of X, Y, Z, ALU and immediate field
//   PC_W    4  program counter width; ROM depth = 2**PC_W
// PORTS
//   clk          in   1              clock; all state changes on rising edge
//   rst          in   1              synchronous, active-high reset
//   run          in   1              1 = execute; 0 = stall in FETCH (PC frozen)
//   imem_addr    out  PC_W           program ROM address (= pc)
//   imem_data    in   OPC_W+DATA_W   ROM word, valid 1 cycle after imem_addr; {opcode, imm}
//   pc           out  PC_W           program counter
//   reg_x        out  DATA_W         X register
//   reg_y        out  DATA_W         Y accumulator
//   reg_z        out  DATA_W         Z register
//   alu_out      out  DATA_W         combinational ALU result for current op
//   zero_flag    out  1              set when last ADD/SUB/MUL/CLRY gave Y == 0
//   carry_flag   out  1              carry (ADD) / no-borrow (SUB) of last ADD/SUB
//   halted       out  1              high in HALTED state
//   retired      out  1              1-cycle pulse per completed instruction
//   illegal      out  1              1-cycle pulse on undefined opcode (executes as NOP)
// BEHAVIOUR
//   Reset: pc, reg_x/y/z, flags, halted, retired, illegal = 0; state = FETCH.
//   Reset mid-instruction aborts it; no register update, no retire pulse that cycle.
//   FSM: FETCH -> DECODE -> EXECUTE -> FETCH; HALT goes EXECUTE -> HALTED (left only by rst).
//     FETCH: imem_addr = pc; advance to DECODE only if run=1.
//     DECODE: latch imem_data into instruction register.
//     EXECUTE: update regs/flags, pc <= pc+1 or jump target, retired = 1 next cycle.
//   Latency: 3 cycles/instruction when run held high; first retire on cycle 3 after rst falls.
//   Opcodes (OPC_W = 4): 0 NOP; 1 LDX X<=imm; 2 ADD Y<=Y+X; 3 SUB Y<=Y-X; 4 MOVZ Z<=Y;
//     5 CLRY Y<=0; 6 JMP pc<=imm[PC_W-1:0]; 7 JZ jump iff zero_flag; 8 HALT; 9 MUL (opt);
//     others: NOP + illegal pulse.
//   Arithmetic modulo 2**DATA_W; carry = bit DATA_W of (DATA_W+1)-bit sum/difference.
//   Flags held by every op that does not list them; JZ reads flag value before EXECUTE.
//   PC wraps 2**PC_W-1 -> 0; imm wider than PC_W truncated, narrower zero-extended.
//   run=0 only stalls in FETCH; an instruction already in DECODE/EXECUTE completes.
//   HALTED: all regs frozen, halted = 1, imem_addr = pc of HALT + 1.
// CONFIGURATION
//   CPU_MUL_EN defined: opcode 9 = MUL, Y <= (X*Y)[DATA_W-1:0], zero_flag updated,
//     carry_flag = |(X*Y)[2*DATA_W-1:DATA_W].
//   Undefined: opcode 9 is illegal (NOP + illegal pulse); no multiplier synthesised.
// STRUCTURE
//   cpu_pkg: OPC_W, opcode localparams/enum, FSM state enum, ALU op enum.
//   Sub-module cpu_alu (DATA_W): op, a, b -> result, carry, zero; purely combinational.
//   Top holds FSM, pc, instruction register, X/Y/Z and flag registers.
// TESTING
//   rst for 2 cycles, program LDX 3; ADD; ADD; MOVZ; HALT -> reg_y=6, reg_z=6, halted=1
//     after 15 cycles, 5 retire pulses.
//   DATA_W=4: LDX 9; ADD; ADD -> reg_y=2, carry_flag=1; then LDX 2; SUB -> reg_y=0,
//     zero_flag=1, carry_flag=1 (no borrow).
//   Loop: LDX 1; ADD; JZ 0; JMP 1 with CLRY preset -> pc never reaches 4; JZ taken only
//     when Y wraps to 0 (after 16 ADDs).
//   PC wrap: 16 NOPs, PC_W=4 -> pc returns 0 at instruction 17, no illegal pulse.
//   Opcode 15 -> illegal pulse 1 cycle, regs unchanged; opcode 9 with/without CPU_MUL_EN:
//     X=3,Y=5 -> reg_y=15 (MUL) or illegal pulse and reg_y=5.
//   rst asserted in EXECUTE of ADD -> reg_y=0, no retire pulse, FETCH at pc=0 next cycle;
//     run=0 for 5 cycles -> pc and regs frozen, resumes identically.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU.
//   OPC_W      : opcode field width (upper bits of each instruction word)
//   opcode_e   : instruction opcodes
//   state_e    : control FSM states
//   alu_op_e   : operations understood by cpu_alu
package cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_LDX  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MOVZ = 4'd4,
    OP_CLRY = 4'd5,
    OP_JMP  = 4'd6,
    OP_JZ   = 4'd7,
    OP_HALT = 4'd8,
    OP_MUL  = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'd0,
    ALU_PASS_B = 3'd1,
    ALU_ADD    = 3'd2,
    ALU_SUB    = 3'd3,
    ALU_MUL    = 3'd4,
    ALU_CLR    = 3'd5
  } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// Purely combinational ALU for the accumulator CPU.
// Configuration macro: CPU_MUL_EN (adds the ALU_MUL operation).
// Ports:
//   op_i     : operation select (alu_op_e)
//   a_i      : first operand (accumulator Y)
//   b_i      : second operand (X or immediate)
//   result_o : DATA_W-bit result, modulo 2**DATA_W
//   carry_o  : ADD carry-out / SUB no-borrow / MUL overflow; 0 otherwise
//   zero_o   : result_o == 0
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] sum;
`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  always_comb begin
    sum      = '0;
    result_o = a_i;
    carry_o  = 1'b0;
`ifdef CPU_MUL_EN
    prod     = '0;
`endif
    case (op_i)
      ALU_PASS_A: result_o = a_i;
      ALU_PASS_B: result_o = b_i;
      ALU_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      ALU_SUB: begin
        // a + ~b + 1: the top bit is set exactly when no borrow occurs.
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
`ifdef CPU_MUL_EN
      ALU_MUL: begin
        prod     = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
        result_o = prod[DATA_W-1:0];
        carry_o  = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      ALU_CLR: result_o = '0;
      default: result_o = a_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle accumulator CPU: FETCH -> DECODE -> EXECUTE, one instruction
// every three cycles, with X (operand), Y (accumulator), Z (snapshot),
// zero/carry flags, conditional jump and retire/illegal strobes.
// Configuration macro: CPU_MUL_EN (opcode 9 = MUL; otherwise opcode 9 is illegal).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   run           : execute enable, only consulted in FETCH
//   imem_addr     : program ROM address (= pc)
//   imem_data     : ROM word {opcode, imm}, valid one cycle after imem_addr
//   pc            : program counter
//   reg_x/y/z     : architectural registers
//   alu_out       : combinational ALU result for the latched instruction
//   zero_flag     : Y == 0 after last ADD/SUB/MUL/CLRY
//   carry_flag    : carry/no-borrow/overflow of last ADD/SUB/MUL
//   halted        : high in HALTED
//   retired       : one-cycle pulse per completed instruction
//   illegal       : one-cycle pulse for an undefined opcode (run as NOP)
//   dbg_state     : current FSM state (state_e encoding) for observation
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [OPC_W+DATA_W-1:0] imem_data,
  output logic [PC_W-1:0]         pc,
  output logic [DATA_W-1:0]       reg_x,
  output logic [DATA_W-1:0]       reg_y,
  output logic [DATA_W-1:0]       reg_z,
  output logic [DATA_W-1:0]       alu_out,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic                    halted,
  output logic                    retired,
  output logic                    illegal,
  output logic [1:0]              dbg_state
);

  localparam int IW = OPC_W + DATA_W;

  // Handshake: run is a level qualifier with no ready side. It is looked at
  // only in FETCH; while low the CPU sits in FETCH with pc frozen. Once an
  // instruction has left FETCH it always completes regardless of run.

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              zf_q, zf_d, cf_q, cf_d;
  logic              retired_q, retired_d, illegal_q, illegal_d;

  opcode_e             opcode;
  logic [DATA_W-1:0]   imm;
  logic [PC_W+DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]     jmp_tgt;

  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_zero;

  assign opcode  = opcode_e'(ir_q[IW-1 -: OPC_W]);
  assign imm     = ir_q[DATA_W-1:0];
  // Zero-extend then take the low PC_W bits: truncates a wide immediate and
  // zero-extends a narrow one without width-dependent generate code.
  assign imm_ext = {{PC_W{1'b0}}, imm};
  assign jmp_tgt = imm_ext[PC_W-1:0];

  // Operation decode for the ALU; X/Y/Z writes all take alu_res.
  always_comb begin
    alu_op = ALU_PASS_A;
    alu_b  = x_q;
    case (opcode)
      OP_LDX: begin
        alu_op = ALU_PASS_B;
        alu_b  = imm;
      end
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_CLRY: alu_op = ALU_CLR;
`ifdef CPU_MUL_EN
      OP_MUL:  alu_op = ALU_MUL;
`endif
      default: alu_op = ALU_PASS_A;
    endcase
  end

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (alu_op),
    .a_i      (y_q),
    .b_i      (alu_b),
    .result_o (alu_res),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    retired_d = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ROM answered the address presented during FETCH.
        ir_d    = imem_data;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d   = S_FETCH;
        pc_d      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        retired_d = 1'b1;
        case (opcode)
          OP_NOP:  ;
          OP_LDX:  x_d = alu_res;
          OP_ADD, OP_SUB: begin
            y_d  = alu_res;
            zf_d = alu_zero;
            cf_d = alu_carry;
          end
          OP_MOVZ: z_d = alu_res;
          OP_CLRY: begin
            y_d  = alu_res;
            zf_d = alu_zero;
          end
          OP_JMP:  pc_d = jmp_tgt;
          // Uses the flag as it stood before this instruction.
          OP_JZ:   if (zf_q) pc_d = jmp_tgt;
          OP_HALT: state_d = S_HALTED;
`ifdef CPU_MUL_EN
          OP_MUL: begin
            y_d  = alu_res;
            zf_d = alu_zero;
            cf_d = alu_carry;
          end
`endif
          default: illegal_d = 1'b1;
        endcase
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      retired_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign reg_x      = x_q;
  assign reg_y      = y_q;
  assign reg_z      = z_q;
  assign alu_out    = alu_res;
  assign zero_flag  = zf_q;
  assign carry_flag = cf_q;
  assign halted     = (state_q == S_HALTED);
  assign retired    = retired_q;
  assign illegal    = illegal_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle (DATA_W = 4, PC_W = 4). An instruction-level model
// steps once per retire pulse and is compared with the DUT every cycle;
// directed programs add literal expectations for timing and final values.
module tb_cpu_multicycle;

  localparam int DATA_W = 4;
  localparam int PC_W   = 4;
  localparam int IW     = 4 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b1;
  always #5 clk = ~clk;

  logic rst_s = 1'b1;
  always @(posedge clk) rst_s <= rst;

  // ---------------- DUT and program ROM ----------------
  logic [PC_W-1:0]   imem_addr, pc;
  logic [IW-1:0]     imem_data = '0;
  logic [DATA_W-1:0] reg_x, reg_y, reg_z, alu_out;
  logic              zero_flag, carry_flag, halted, retired, illegal;
  logic [1:0]        dbg_state;

  logic [IW-1:0] rom [16];
  always @(posedge clk) imem_data <= rom[imem_addr];

  cpu_multicycle #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .pc         (pc),
    .reg_x      (reg_x),
    .reg_y      (reg_y),
    .reg_z      (reg_z),
    .alu_out    (alu_out),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .halted     (halted),
    .retired    (retired),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  int m_pc, m_x, m_y, m_z, m_zf, m_cf, m_halt, m_ill;
  int ret_cnt, ill_cnt, max_pc;

  task automatic model_reset();
    m_pc = 0; m_x = 0; m_y = 0; m_z = 0;
    m_zf = 0; m_cf = 0; m_halt = 0; m_ill = 0;
  endtask

  task automatic model_step();
    int op, imm, npc, r;
    op  = int'(rom[m_pc][7:4]);
    imm = int'(rom[m_pc][3:0]);
    npc = (m_pc + 1) % 16;
    m_ill = 0;
    case (op)
      0: ;
      1: m_x = imm;
      2: begin r = m_y + m_x; m_y = r % 16; m_cf = (r >= 16); m_zf = (m_y == 0); end
      3: begin m_cf = (m_y >= m_x); m_y = (m_y - m_x + 16) % 16; m_zf = (m_y == 0); end
      4: m_z = m_y;
      5: begin m_y = 0; m_zf = 1; end
      6: npc = imm;
      7: if (m_zf != 0) npc = imm;
      8: m_halt = 1;
`ifdef CPU_MUL_EN
      9: begin r = m_x * m_y; m_y = r % 16; m_cf = (r >= 16); m_zf = (m_y == 0); end
`endif
      default: m_ill = 1;
    endcase
    m_pc = npc;
  endtask

  // Compare process: every cycle, DUT architectural state must equal the model.
  always @(negedge clk) begin
    int exp_ill;
    exp_ill = 0;
    if (rst_s) begin
      model_reset();
      ret_cnt = 0;
      ill_cnt = 0;
      max_pc  = 0;
      chk("reset_retired", 32'(retired), 0);
    end else if (m_halt != 0) begin
      chk("retire_after_halt", 32'(retired), 0);
    end else if (retired) begin
      model_step();
      ret_cnt++;
      exp_ill = m_ill;
    end
    if (illegal) ill_cnt++;
    if (int'(pc) > max_pc) max_pc = int'(pc);
    chk("pc",        32'(pc),         m_pc);
    chk("imem_addr", 32'(imem_addr),  m_pc);
    chk("reg_x",     32'(reg_x),      m_x);
    chk("reg_y",     32'(reg_y),      m_y);
    chk("reg_z",     32'(reg_z),      m_z);
    chk("zero_flag", 32'(zero_flag),  m_zf);
    chk("carry_flag",32'(carry_flag), m_cf);
    chk("halted",    32'(halted),     m_halt);
    chk("illegal",   32'(illegal),    exp_ill);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = '0;
  endtask

  task automatic put(input int addr, input int op, input int imm);
    rom[addr] = {op[3:0], imm[3:0]};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_retires(input int n, input int max_cyc);
    int cyc;
    cyc = 0;
    while (ret_cnt < n && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    chk("retire_wait", ret_cnt, n);
  endtask

  task automatic run_halt(input int max_cyc, output int cyc);
    cyc = 0;
    while (!halted && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    chk("halt_wait", 32'(halted), 1);
  endtask

  // ---------------- directed programs ----------------
  initial begin
    int cyc, c2;

    // Program 1: LDX 3; ADD; ADD; MOVZ; HALT
    clear_rom();
    put(0, 1, 3); put(1, 2, 0); put(2, 2, 0); put(3, 4, 0); put(4, 8, 0);
    run = 1'b1;
    do_reset();
    chk("p1_reset_y", 32'(reg_y), 0);
    chk("p1_reset_state", 32'(dbg_state), 0);
    cyc = 0;
    while (!retired && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("p1_first_retire_cycle", cyc, 3);
    run_halt(40, c2);
    chk("p1_halt_cycle", cyc + c2, 15);
    chk("p1_y", 32'(reg_y), 6);
    chk("p1_z", 32'(reg_z), 6);
    chk("p1_retires", ret_cnt, 5);
    repeat (3) tick();
    chk("p1_halt_addr", 32'(imem_addr), 5);

    // Program 2: LDX 9; ADD; ADD; LDX 2; SUB; HALT
    clear_rom();
    put(0, 1, 9); put(1, 2, 0); put(2, 2, 0); put(3, 1, 2); put(4, 3, 0); put(5, 8, 0);
    do_reset();
    run_retires(3, 20);
    chk("p2_add_wrap_y", 32'(reg_y), 2);
    chk("p2_add_carry", 32'(carry_flag), 1);
    chk("p2_add_zero", 32'(zero_flag), 0);
    run_halt(20, cyc);
    chk("p2_sub_y", 32'(reg_y), 0);
    chk("p2_sub_zero", 32'(zero_flag), 1);
    chk("p2_sub_noborrow", 32'(carry_flag), 1);

    // Program 3: loop LDX 1; ADD; JZ 0; JMP 1
    clear_rom();
    put(0, 1, 1); put(1, 2, 0); put(2, 7, 0); put(3, 6, 1);
    do_reset();
    run_retires(3, 20);
    chk("p3_jz_not_taken_pc", 32'(pc), 3);
    chk("p3_y1", 32'(reg_y), 1);
    run_retires(48, 200);
    chk("p3_jz_taken_pc", 32'(pc), 0);
    chk("p3_y_wrapped", 32'(reg_y), 0);
    chk("p3_zero", 32'(zero_flag), 1);
    chk("p3_pc_bound", max_pc, 3);

    // Program 4: all NOPs, pc wraps
    clear_rom();
    do_reset();
    run_retires(16, 80);
    chk("p4_pc_wrap", 32'(pc), 0);
    run_retires(17, 10);
    chk("p4_pc_after17", 32'(pc), 1);
    chk("p4_no_illegal", ill_cnt, 0);

    // Program 5: LDX 5; ADD; LDX 3; op15; op9; HALT
    clear_rom();
    put(0, 1, 5); put(1, 2, 0); put(2, 1, 3); put(3, 15, 7); put(4, 9, 0); put(5, 8, 0);
    do_reset();
    run_retires(4, 30);
    chk("p5_illegal_pulse", 32'(illegal), 1);
    chk("p5_x_kept", 32'(reg_x), 3);
    chk("p5_y_kept", 32'(reg_y), 5);
    tick();
    chk("p5_illegal_one_cycle", 32'(illegal), 0);
    run_halt(20, cyc);
`ifdef CPU_MUL_EN
    chk("p5_mul_y", 32'(reg_y), 15);
    chk("p5_illegal_count", ill_cnt, 1);
`else
    chk("p5_op9_y", 32'(reg_y), 5);
    chk("p5_illegal_count", ill_cnt, 2);
`endif

    // Program 6: reset inside EXECUTE of ADD, then a run stall
    clear_rom();
    put(0, 1, 3); put(1, 2, 0); put(2, 8, 0);
    do_reset();
    repeat (5) tick();
    chk("p6_in_execute", 32'(dbg_state), 2);
    chk("p6_x_before", 32'(reg_x), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("p6_abort_y", 32'(reg_y), 0);
    chk("p6_abort_x", 32'(reg_x), 0);
    chk("p6_abort_retired", 32'(retired), 0);
    chk("p6_abort_pc", 32'(pc), 0);
    chk("p6_abort_state", 32'(dbg_state), 0);
    repeat (3) tick();
    chk("p6_ldx_retired", 32'(retired), 1);
    run = 1'b0;
    repeat (5) tick();
    chk("p6_stall_pc", 32'(pc), 1);
    chk("p6_stall_state", 32'(dbg_state), 0);
    chk("p6_stall_retires", ret_cnt, 1);
    run = 1'b1;
    run_halt(20, cyc);
    chk("p6_resume_cycles", cyc, 6);
    chk("p6_y", 32'(reg_y), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
